decomp_sequencer: RTL and testbench

DECOMP_SEQUENCER -- requirements
Module: decomp_sequencer

---
 rtl/decomp_sequencer_if.sv | 40 ++++
 rtl/decomp_sequencer.sv | 141 ++++++++++++++
 tb/tb_decomp_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decomp_sequencer_if.sv
// Bundle of the sequencer's control handshake, per-stage SRAM request buses
// and the shared SRAM port. The sequencer uses the slave view; the host,
// the stage engines and the SRAM model sit on the master side.
interface decomp_sequencer_if #(
    parameter int DW = 16,
    parameter int AW = 18
);
    logic              start;
    logic [3:0]        stage_en;
    logic              done;
    logic              busy;
    logic [1:0]        cur_stage;
    logic [3:0]        stage_start;
    logic [3:0]        stage_done;
    logic [4*AW-1:0]   stage_raddr;
    logic [4*AW-1:0]   stage_waddr;
    logic [4*DW-1:0]   stage_wdata;
    logic [3:0]        stage_wr_enable;
    logic [AW-1:0]     raddr;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic              wr_enable;
    logic [DW-1:0]     rdata;
    logic [DW-1:0]     stage_rdata;
    logic              error;

    modport slave (
        input  start, stage_en, stage_done, stage_raddr, stage_waddr,
               stage_wdata, stage_wr_enable, rdata,
        output done, busy, cur_stage, stage_start, raddr, waddr, wdata,
               wr_enable, stage_rdata, error
    );

    modport master (
        output start, stage_en, stage_done, stage_raddr, stage_waddr,
               stage_wdata, stage_wr_enable, rdata,
        input  done, busy, cur_stage, stage_start, raddr, waddr, wdata,
               wr_enable, stage_rdata, error
    );
endinterface

// File: rtl/decomp_sequencer.sv
// decomp_sequencer: runs up to four decompression stages one after another,
// lowest enabled index first, and hands the single SRAM port to whichever
// stage is active. Optional feature macro: SEQ_TIMEOUT_EN (per-stage RUN
// watchdog that aborts the sequence and raises a sticky error).
module decomp_sequencer #(
    parameter int DW          = 16,
    parameter int AW          = 18,
    parameter int TIMEOUT_CYC = 262143
) (
    input  logic               clk,
    input  logic               reset,
    decomp_sequencer_if.slave  bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LAUNCH = 3'd1;
    localparam logic [2:0] RUN    = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    logic [2:0] state_q, state_d;
    logic [3:0] mask_q, mask_d;
    logic [1:0] cur_q, cur_d;
    logic       err_q, err_d;

    logic [3:0] rem;       // mask with the current stage retired
    logic [3:0] pick_src;  // bit set the next stage is chosen from
    logic [1:0] nxt;       // lowest set bit of pick_src
    logic       timeout;

`ifdef SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q;

    // RUN-cycle watchdog: restarts at every launch, counts RUN cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                cnt_q <= '0;
        else if (state_q == LAUNCH) cnt_q <= '0;
        else if (state_q == RUN)  cnt_q <= cnt_q + 1'b1;
    end

    // the RUN cycle that brings the count to TIMEOUT_CYC ends the stage
    assign timeout = (state_q == RUN) && (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // pick the next stage: lowest enabled bit on start, else the lowest
    // still-pending bit, which is always above the stage just retired
    always_comb begin
        rem      = mask_q & ~(4'b0001 << cur_q);
        pick_src = (state_q == IDLE) ? bus.stage_en : rem;
        nxt      = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pick_src[i]) nxt = 2'(i);
        end
    end

    // sequencing FSM next-state
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cur_d   = cur_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mask_d = bus.stage_en;
                    err_d  = 1'b0;
                    if (|bus.stage_en) begin
                        state_d = LAUNCH;
                        cur_d   = nxt;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            LAUNCH: state_d = RUN;
            RUN: begin
                if (bus.stage_done[cur_q]) begin
                    state_d = GAP;
                end else if (timeout) begin
                    state_d = FINISH;
                    err_d   = 1'b1;
                    mask_d  = 4'b0000;
                end
            end
            GAP: begin
                mask_d = rem;
                if (|rem) begin
                    state_d = LAUNCH;
                    cur_d   = nxt;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // sequencer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= 4'b0000;
            cur_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cur_q   <= cur_d;
            err_q   <= err_d;
        end
    end

    // status and stage-start outputs decode straight from registered state,
    // so reset clears them in the same instant
    always_comb begin
        bus.done        = (state_q == FINISH);
        bus.busy        = (state_q != IDLE);
        bus.cur_stage   = cur_q;
        bus.error       = err_q;
        bus.stage_start = (state_q == LAUNCH) ? (4'b0001 << cur_q) : 4'b0000;
        bus.stage_rdata = bus.rdata;
    end

    // shared SRAM mux: only the owning stage reaches the port, and only
    // while it is launching or running
    always_comb begin
        bus.raddr     = '0;
        bus.waddr     = '0;
        bus.wdata     = '0;
        bus.wr_enable = 1'b0;
        if (state_q == LAUNCH || state_q == RUN) begin
            bus.raddr     = bus.stage_raddr[cur_q*AW +: AW];
            bus.waddr     = bus.stage_waddr[cur_q*AW +: AW];
            bus.wdata     = bus.stage_wdata[cur_q*DW +: DW];
            bus.wr_enable = bus.stage_wr_enable[cur_q];
        end
    end
endmodule

// File: tb/tb_decomp_sequencer.sv
// Directed bench for decomp_sequencer. Acts as host, stage engines and SRAM.
// Build with SEQ_TIMEOUT_EN defined to also exercise the watchdog.
module tb_decomp_sequencer;
    localparam int DW = 16;
    localparam int AW = 18;
`ifdef SEQ_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 262143;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decomp_sequencer_if #(.DW(DW), .AW(AW)) bus ();

    decomp_sequencer #(.DW(DW), .AW(AW), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // per-run observations
    int          st_q[$];
    int          st_cyc[$];
    int          done_cyc;
    int          n_done;
    int          busy_gap;
    logic        busy_after;
    logic        err_seen;
    logic        err_at_done;
    logic [AW-1:0] snap_raddr;
    logic [AW-1:0] snap_waddr;
    logic        snap_we;

    // Start a sequence with mask en; every launched stage raises stage_done
    // for one cycle dly cycles after its start pulse. Cycle 0 is the start
    // cycle; cycle numbers count rising edges after it.
    task automatic run_seq(input logic [3:0] en, input int dly, input int snap_at);
        int sc[4];
        int cyc;
        bit fin;
        st_q.delete();
        st_cyc.delete();
        done_cyc = -1; n_done = 0; busy_gap = 0;
        busy_after = 1'b1; err_seen = 1'b0; err_at_done = 1'b0;
        for (int i = 0; i < 4; i++) sc[i] = -1000;
        bus.start = 1'b1;
        bus.stage_en = en;
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 200) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
            if (bus.stage_start != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.stage_start[i]) begin
                        st_q.push_back(i);
                        st_cyc.push_back(cyc);
                        sc[i] = cyc;
                        chk("launch_cur", 32'(bus.cur_stage), 32'(i));
                        chk("launch_raddr", 32'(bus.raddr), 32'('h100 + i));
                    end
                end
            end
            if (cyc == snap_at) begin
                snap_raddr = bus.raddr;
                snap_waddr = bus.waddr;
                snap_we    = bus.wr_enable;
            end
            if (bus.error) err_seen = 1'b1;
            if (done_cyc >= 0) begin
                busy_after = bus.busy;
                fin = 1'b1;
            end
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    err_at_done = bus.error;
                end
            end
            if (!bus.busy && done_cyc < 0) busy_gap++;
            for (int i = 0; i < 4; i++) bus.stage_done[i] = (cyc == sc[i] + dly);
        end
        bus.stage_done = 4'b0000;
        chk("seq_bound", 32'(fin), 32'd1);
    endtask

    function automatic int q_at(input int idx);
        return (st_q.size() > idx) ? st_q[idx] : -1;
    endfunction

    function automatic int c_at(input int idx);
        return (st_cyc.size() > idx) ? st_cyc[idx] : -1;
    endfunction

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.stage_en = 4'b0000;
        bus.stage_done = 4'b0000;
        bus.stage_wr_enable = 4'b0000;
        bus.rdata = 16'h5A5A;
        for (int i = 0; i < 4; i++) begin
            bus.stage_raddr[i*AW +: AW] = AW'('h100 + i);
            bus.stage_waddr[i*AW +: AW] = AW'('h200 + i);
            bus.stage_wdata[i*DW +: DW] = DW'('h1000 + i);
        end

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_start", 32'(bus.stage_start), 32'd0);
        chk("rst_cur", 32'(bus.cur_stage), 32'd0);
        chk("rst_err", 32'(bus.error), 32'd0);
        chk("rst_raddr", 32'(bus.raddr), 32'd0);
        chk("rdata_fan", 32'(bus.stage_rdata), 32'h5A5A);
        reset = 1'b0;
        @(posedge clk); #1;

        // all four stages, done 5 cycles after each start
        run_seq(4'b1111, 5, -1);
        chk("all_cnt", 32'(st_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("all_order", 32'(q_at(i)), 32'(i));
            chk("all_cyc", 32'(c_at(i)), 32'(1 + 7*i));
        end
        chk("all_done_cyc", 32'(done_cyc), 32'd29);
        chk("all_done_w", 32'(n_done), 32'd1);
        chk("all_busy_gap", 32'(busy_gap), 32'd0);
        chk("all_busy_end", 32'(busy_after), 32'd0);
        chk("all_err", 32'(err_seen), 32'd0);

        // sparse mask 1010, snapshot SRAM port in the GAP cycle
        run_seq(4'b1010, 5, 7);
        chk("sp_cnt", 32'(st_q.size()), 32'd2);
        chk("sp_first", 32'(q_at(0)), 32'd1);
        chk("sp_second", 32'(q_at(1)), 32'd3);
        chk("sp_cyc1", 32'(c_at(1)), 32'd8);
        chk("sp_gap_raddr", 32'(snap_raddr), 32'd0);
        chk("sp_gap_waddr", 32'(snap_waddr), 32'd0);
        chk("sp_done_cyc", 32'(done_cyc), 32'd15);

        // empty mask: done on the cycle right after start
        run_seq(4'b0000, 5, -1);
        chk("nil_cnt", 32'(st_q.size()), 32'd0);
        chk("nil_done_cyc", 32'(done_cyc), 32'd1);
        chk("nil_done_w", 32'(n_done), 32'd1);

        // SRAM mux ownership with stage 2 running
        bus.stage_waddr[2*AW +: AW] = 18'h1C200;
        bus.stage_wdata[2*DW +: DW] = 16'hABCD;
        bus.stage_wr_enable = 4'b0101;
        bus.stage_en = 4'b0100;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("mux_launch", 32'(bus.stage_start), 32'h4);
        @(posedge clk); #1;
        chk("mux_waddr", 32'(bus.waddr), 32'h1C200);
        chk("mux_wdata", 32'(bus.wdata), 32'hABCD);
        chk("mux_we", 32'(bus.wr_enable), 32'd1);
        chk("mux_cur", 32'(bus.cur_stage), 32'd2);
        bus.stage_wr_enable = 4'b0001;
        bus.stage_done = 4'b0001;
        #1;
        chk("mux_we_other", 32'(bus.wr_enable), 32'd0);
        @(posedge clk); #1;
        chk("mux_other_done", 32'(bus.raddr), 32'h102);
        chk("mux_busy", 32'(bus.busy), 32'd1);
        bus.stage_done = 4'b0100;
        @(posedge clk); #1;
        bus.stage_done = 4'b0000;
        chk("mux_gap_waddr", 32'(bus.waddr), 32'd0);
        @(posedge clk); #1;
        chk("mux_done", 32'(bus.done), 32'd1);
        @(posedge clk); #1;

        // reset 3 cycles into stage 1 RUN, then restart
        bus.stage_wr_enable = 4'b0010;
        bus.stage_en = 4'b0110;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mr_pre_we", 32'(bus.wr_enable), 32'd1);
        chk("mr_pre_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_done", 32'(bus.done), 32'd0);
        chk("mr_start", 32'(bus.stage_start), 32'd0);
        chk("mr_cur", 32'(bus.cur_stage), 32'd0);
        chk("mr_raddr", 32'(bus.raddr), 32'd0);
        chk("mr_we", 32'(bus.wr_enable), 32'd0);
        chk("mr_err", 32'(bus.error), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mr_post_start", 32'(bus.stage_start), 32'd0);
        chk("mr_post_done", 32'(bus.done), 32'd0);
        run_seq(4'b0110, 5, -1);
        chk("mr_first", 32'(q_at(0)), 32'd1);
        chk("mr_first_cyc", 32'(c_at(0)), 32'd1);
        chk("mr_second", 32'(q_at(1)), 32'd2);
        chk("mr_done_cyc", 32'(done_cyc), 32'd15);

`ifdef SEQ_TIMEOUT_EN
        // stage 0 never finishes: watchdog ends the sequence
        @(posedge clk); #1;
        run_seq(4'b0011, 1000, -1);
        chk("to_cnt", 32'(st_q.size()), 32'd1);
        chk("to_done_cyc", 32'(done_cyc), 32'd18);
        chk("to_err_done", 32'(err_at_done), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("to_err_hold", 32'(bus.error), 32'd1);
        run_seq(4'b0000, 5, -1);
        chk("to_err_clr", 32'(err_at_done), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
